// File: rtl/mult_seq_ctrl_if.sv
// Handshake and datapath bundle between the sequential multiply controller,
// its host and the external array-multiplier datapath.
interface mult_seq_ctrl_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;
    logic [7:0]  mul_a;
    logic [7:0]  mul_b;
    logic [15:0] mul_p;

    // Host side: offers operands, consumes product bytes, returns the datapath product
    modport master (
        output in_valid, in_data, out_ready, mul_p,
        input  in_ready, out_valid, out_data, mul_a, mul_b
    );

    // Controller side
    modport slave (
        input  in_valid, in_data, out_ready, mul_p,
        output in_ready, out_valid, out_data, mul_a, mul_b
    );
endinterface

// File: rtl/mult_seq_ctrl.sv
// Sequential multiply controller: collects two operand bytes, waits for the
// array multiplier to settle, then returns the 16-bit product low byte first.
module mult_seq_ctrl #(
    parameter int unsigned MUL_LAT = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           ena,
    mult_seq_ctrl_if.slave bus,
    output logic           busy,
    output logic [7:0]     op_count
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GET_B  = 3'd1,
        WAIT   = 3'd2,
        OUT_LO = 3'd3,
        OUT_HI = 3'd4
    } state_t;

    localparam logic [3:0] LAT_INIT = 4'(MUL_LAT);

    state_t      state_q;
    logic [7:0]  opA_q;
    logic [7:0]  opB_q;
    logic [15:0] product_q;
    logic [3:0]  waitCnt_q;
    logic [7:0]  opCount_q;
    logic        busy_q;

    // Handshake qualifiers and output byte selection decoded from the current state
    always_comb begin
        bus.in_ready  = ena && ((state_q == IDLE) || (state_q == GET_B));
        bus.out_valid = ena && ((state_q == OUT_LO) || (state_q == OUT_HI));
        bus.out_data  = 8'h00;
        if (state_q == OUT_LO) begin
            bus.out_data = product_q[7:0];
        end else if (state_q == OUT_HI) begin
            bus.out_data = product_q[15:8];
        end
        bus.mul_a = opA_q;
        bus.mul_b = opB_q;
        busy      = busy_q;
        op_count  = opCount_q;
    end

    // Controller FSM; every register holds while ena is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            opA_q     <= 8'h00;
            opB_q     <= 8'h00;
            product_q <= 16'h0000;
            waitCnt_q <= 4'd0;
            opCount_q <= 8'h00;
            busy_q    <= 1'b0;
        end else if (ena) begin
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        opA_q   <= bus.in_data;
                        state_q <= GET_B;
                        busy_q  <= 1'b1;
                    end
                end
                GET_B: begin
                    if (bus.in_valid) begin
                        opB_q     <= bus.in_data;
                        waitCnt_q <= LAT_INIT;
                        state_q   <= WAIT;
                    end
                end
                WAIT: begin
                    waitCnt_q <= waitCnt_q - 4'd1;
                    if (waitCnt_q == 4'd1) begin
                        product_q <= bus.mul_p;
                        state_q   <= OUT_LO;
                    end
                end
                OUT_LO: begin
                    if (bus.out_ready) begin
                        state_q <= OUT_HI;
                    end
                end
                OUT_HI: begin
                    if (bus.out_ready) begin
                        state_q   <= IDLE;
                        busy_q    <= 1'b0;
                        opCount_q <= opCount_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule
